// File: rtl/rca_seq_ctrl_pkg.sv
// Shared definitions for the sequential ripple-carry adder controller.
package rca_seq_ctrl_pkg;

    localparam int DEF_N     = 4;
    localparam int DEF_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice index width; a single-slice build still needs a 1-bit index.
    function automatic int idx_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/rca_nbits.sv
// N-bit ripple-carry adder slice built from a chain of full adders.
module rca_nbits #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] s,
    output logic         cout
);

    logic [n:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < n; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[n];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Sequential adder: reuses one N-bit ripple slice WORDS times per operand pair,
// low slice first, with a valid/ready handshake on both sides.
module rca_seq_ctrl
    import rca_seq_ctrl_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WORDS = DEF_WORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*WORDS-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int W  = N * WORDS;
    localparam int IW = idx_w(WORDS);

    state_t        r_state, w_next;
    logic [IW-1:0] r_idx;
    logic          r_c;
    logic [W-1:0]  r_a, r_b;
    logic [W-1:0]  r_sum;
    logic          r_cout;

    logic          w_hs, w_last;
    logic [N-1:0]  w_a_sl, w_b_sl, w_s;
    logic          w_co;

    assign w_hs   = in_valid && (r_state == IDLE);
    assign w_last = (r_idx == IW'(WORDS - 1));
    assign w_a_sl = r_a[r_idx*N +: N];
    assign w_b_sl = r_b[r_idx*N +: N];

    rca_nbits #(.n(N)) u_slice (
        .a    (w_a_sl),
        .b    (w_b_sl),
        .cin  (r_c),
        .s    (w_s),
        .cout (w_co)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand capture; contents are don't-care until the next handshake.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_a <= a;
            r_b <= b;
        end
    end

    // Slice datapath: one slice per edge in RUN, results frozen otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_c    <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_hs) begin
            r_idx <= '0;
            r_c   <= cin;
        end else if (r_state == RUN) begin
            r_sum[r_idx*N +: N] <= w_s;
            r_c                 <= w_co;
            if (w_last) begin
                r_cout <= w_co;
                r_idx  <= '0;
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Scoreboard bench: the driver queues expected {cout,sum} and handshake cycle,
// the monitor checks value, latency and hold stability while out_valid is up.
module tb_rca_seq_ctrl;

    localparam int N     = 4;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    typedef struct {
        logic [W:0] exp;
        int         hs;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [W-1:0] a, b, sum;

    logic         in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
    logic [N-1:0] a1, b1, sum1;

    int  total = 0, bad = 0, cyc = 0;
    int  n_sent = 0, n_got = 0, last_hs = 0;
    bit  bp = 0;
    sb_t sbq[$];

    rca_seq_ctrl #(.N(N), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    rca_seq_ctrl #(.N(N), .WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (bp) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Present operands, wait for acceptance, optionally keep driving junk in RUN.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic [W:0] exp, input bit junk);
        int n;
        in_valid = 1'b1; a = ta; b = tb_; cin = tc;
        n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        chk("accept_timeout", 64'(in_ready), 64'd1);
        last_hs = cyc + 1;
        sbq.push_back('{exp: exp, hs: cyc + 1});
        n_sent++;
        tick();
        if (junk) begin
            for (int k = 0; k < WORDS - 1; k++) begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                chk("in_ready_run", 64'(in_ready), 64'd0);
                chk("busy_run", 64'(busy), 64'd1);
                tick();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_ov();
        int n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        chk("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin tick(); n++; end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    // Monitor: pops on each rising out_valid, checks stability while held.
    initial begin : monitor
        logic       prev_ov;
        logic [W:0] cur;
        prev_ov = 1'b0;
        cur     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid && !prev_ov) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_result", 64'(sbq.size()), 64'd1);
                    end else begin
                        sb_t e;
                        e   = sbq.pop_front();
                        cur = e.exp;
                        n_got++;
                        chk("latency", 64'(cyc - e.hs), 64'(WORDS));
                    end
                end
                if (out_valid) chk("result", 64'({cout, sum}), 64'(cur));
                prev_ov = out_valid;
            end
        end
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;
        int           hs1;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sum", 64'({cout, sum}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_out_valid", 64'(out_valid), 64'd0);

        // Full carry ripple through every slice.
        out_ready = 1'b1;
        send(16'hFFFF, 16'h0001, 1'b0, {1'b1, 16'h0000}, 0);
        wait_idle();

        // Result must hold under backpressure.
        out_ready = 1'b0;
        send(16'h1234, 16'h4321, 1'b1, {1'b0, 16'h5556}, 0);
        wait_ov();
        for (int k = 0; k < 5; k++) tick();
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_value", 64'({cout, sum}), 64'({1'b0, 16'h5556}));
        out_ready = 1'b1;
        wait_idle();

        // Back-to-back throughput with out_ready held high.
        send(16'h0001, 16'h0002, 1'b0, {1'b0, 16'h0003}, 0);
        hs1 = last_hs;
        send(16'h8000, 16'h8000, 1'b1, {1'b1, 16'h0001}, 0);
        chk("throughput", 64'(last_hs - hs1), 64'(WORDS + 2));
        wait_idle();

        // New operands during RUN must be ignored.
        send(16'h0F0F, 16'h00F1, 1'b0, {1'b0, 16'h1000}, 1);
        wait_idle();

        // Abort mid-RUN with asynchronous reset.
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
        chk("abort_accept", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("abort_partial_nonzero", 64'(sum != '0), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_sum", 64'({cout, sum}), 64'd0);
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send(16'h00FF, 16'h0F01, 1'b0, {1'b0, 16'h1000}, 0);
        wait_idle();

        // Random operands with random backpressure.
        bp = 1;
        for (int t = 0; t < 1000; t++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            send(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + (W+1)'(rc), 0);
        end
        bp = 0;
        out_ready = 1'b1;
        wait_idle();
        tick();
        chk("all_results_seen", 64'(n_got), 64'(n_sent));

        // Single-slice build.
        in_valid1 = 1'b1; a1 = 4'hF; b1 = 4'hF; cin1 = 1'b1; out_ready1 = 1'b0;
        chk("w1_in_ready", 64'(in_ready1), 64'd1);
        tick();
        in_valid1 = 1'b0;
        chk("w1_running", 64'(out_valid1), 64'd0);
        tick();
        chk("w1_out_valid", 64'(out_valid1), 64'd1);
        chk("w1_result", 64'({cout1, sum1}), 64'({1'b1, 4'hF}));
        out_ready1 = 1'b1;
        tick();
        chk("w1_released", 64'(out_valid1), 64'd0);
        chk("w1_in_ready_again", 64'(in_ready1), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
